bin_div_seq: RTL and testbench

//   Sequential restoring binary divider: unsigned N-bit Dividend / N-bit Divisor -> N-bit

---
 rtl/bin_div_seq_pkg.sv | 20 ++
 rtl/bin_div_seq_div_step.sv | 35 +++
 rtl/bin_div_seq.sv | 124 ++++++++++++
 tb/tb_bin_div_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bin_div_seq_pkg.sv
//==============================================================================
// bin_div_seq_pkg: FSM state encoding and divide-by-zero constant. Rev 1.0
//==============================================================================
`default_nettype none

package bin_div_seq_pkg;

  // Explicit 2-bit encoding so the bench scoreboard and the RTL share one source.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Replicated to N bits to form the all-ones divide-by-zero quotient.
  localparam logic DBZ_Q_BIT = 1'b1;

endpackage : bin_div_seq_pkg

`default_nettype wire

// File: rtl/bin_div_seq_div_step.sv
//==============================================================================
// div_step: one restoring shift-subtract iteration, {R, A, D} -> {R', A'}. Rev 1.0
//==============================================================================
`default_nettype none

module div_step #(
  parameter int N = 8
) (
  input  logic [N:0]   r_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] d_i,
  output logic [N:0]   r_o,
  output logic [N-1:0] a_o
);

  logic [N:0] w_rs;
  logic [N:0] w_t;

  assign w_rs = {r_i[N-1:0], a_i[N-1]};
  assign w_t  = w_rs - {1'b0, d_i};

  // A borrow out of the trial subtraction means the divisor did not fit: restore.
  always_comb begin
    if (!w_t[N]) begin
      r_o = w_t;
      a_o = {a_i[N-2:0], 1'b1};
    end else begin
      r_o = w_rs;
      a_o = {a_i[N-2:0], 1'b0};
    end
  end

endmodule : div_step

`default_nettype wire

// File: rtl/bin_div_seq.sv
//==============================================================================
// bin_div_seq: sequential restoring divider, one quotient bit per clock. Rev 1.0
//==============================================================================
`default_nettype none

module bin_div_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] Dividend,
  input  logic [N-1:0] Divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Quotient,
  output logic [N-1:0] Remainder,
  output logic         div_by_zero
);

  import bin_div_seq_pkg::*;

  localparam int CW = $clog2(N);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   dvs_q, dvs_d;
  logic [N:0]     r_q, r_d;
  logic           done_q, done_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;

  logic [N:0]     step_r;
  logic [N-1:0]   step_a;

  div_step #(.N(N)) u_step (
    .r_i (r_q),
    .a_i (a_q),
    .d_i (dvs_q),
    .r_o (step_r),
    .a_o (step_a)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      dvs_q   <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    dvs_d   = dvs_q;
    r_d     = r_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = Dividend;
          dvs_d   = Divisor;
          r_d     = '0;
          cnt_d   = '0;
          // A zero divisor skips iteration entirely; A keeps the dividend for the remainder.
          state_d = (Divisor == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        a_d   = step_a;
        r_d   = step_r;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dvs_q == '0) begin
          quo_d = {N{DBZ_Q_BIT}};
          rem_d = a_q;
          dbz_d = 1'b1;
        end else begin
          quo_d = a_q;
          rem_d = r_q[N-1:0];
          dbz_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign Quotient    = quo_q;
  assign Remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule : bin_div_seq

`default_nettype wire

// File: tb/tb_bin_div_seq.sv
//==============================================================================
// tb_bin_div_seq: vector table, corner sequences and random ops vs arithmetic model. Rev 1.0
//==============================================================================
`default_nettype none

module tb_bin_div_seq;

  import bin_div_seq_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] Dividend = '0;
  logic [N-1:0] Divisor = '0;
  logic         busy, done, div_by_zero;
  logic [N-1:0] Quotient, Remainder;

  int errors = 0;
  int checks = 0;

  bin_div_seq #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .Dividend    (Dividend),
    .Divisor     (Divisor),
    .busy        (busy),
    .done        (done),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] d;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int bin_mul(input int x, input int y);
    return x * y;
  endfunction

  // Start one op and wait for done; lat counts falling edges after the accepting edge.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] d,
                        output logic [N-1:0] q, output logic [N-1:0] r,
                        output logic z, output int lat, output logic busy1);
    start = 1'b1; Dividend = a; Divisor = d;
    @(negedge clk);
    start = 1'b0;
    busy1 = busy;
    Dividend = $urandom; Divisor = $urandom;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
    q = Quotient; r = Remainder; z = div_by_zero;
  endtask

  initial begin
    vec_t tbl[8];
    logic [N-1:0] q, r;
    logic z, b1;
    int lat, ndone, first_lat;

    tbl[0] = '{8'd100, 8'd7,   8'd14,  8'd2, 1'b0, 10};
    tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 10};
    tbl[2] = '{8'd255, 8'd255, 8'd1,   8'd0, 1'b0, 10};
    tbl[3] = '{8'd3,   8'd200, 8'd0,   8'd3, 1'b0, 10};
    tbl[4] = '{8'd5,   8'd0,   8'hFF,  8'd5, 1'b1, 2};
    tbl[5] = '{8'd9,   8'd3,   8'd3,   8'd0, 1'b0, 10};
    tbl[6] = '{8'd0,   8'd5,   8'd0,   8'd0, 1'b0, 10};
    tbl[7] = '{8'd200, 8'd13,  8'd15,  8'd5, 1'b0, 10};

    repeat (3) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset outputs", int'({Quotient, Remainder, div_by_zero}), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].d, q, r, z, lat, b1);
      check($sformatf("v%0d busy after accept", i), int'(b1), 1);
      check($sformatf("v%0d latency", i), lat, tbl[i].lat);
      check($sformatf("v%0d quotient", i), int'(q), int'(tbl[i].q));
      check($sformatf("v%0d remainder", i), int'(r), int'(tbl[i].r));
      check($sformatf("v%0d dbz", i), int'(z), int'(tbl[i].z));
      check($sformatf("v%0d busy at done", i), int'(busy), 0);
      @(negedge clk);
      check($sformatf("v%0d done single", i), int'(done), 0);
      check($sformatf("v%0d result held", i), int'(Quotient), int'(tbl[i].q));
    end

    // start pulsed mid-RUN with new operands must be ignored
    start = 1'b1; Dividend = 8'd100; Divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; Dividend = 8'd50; Divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; first_lat = -1;
    for (int c = 5; c < 30; c++) begin
      if (done) begin
        ndone++;
        if (first_lat < 0) begin
          first_lat = c;
          q = Quotient; r = Remainder;
        end
      end
      @(negedge clk);
    end
    check("midrun done count", ndone, 1);
    check("midrun latency", first_lat, 10);
    check("midrun quotient", int'(q), 14);
    check("midrun remainder", int'(r), 2);

    // reset four cycles into RUN aborts without a done pulse
    start = 1'b1; Dividend = 8'd200; Divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", int'(busy), 0);
    check("abort outputs", int'({Quotient, Remainder, div_by_zero}), 0);
    ndone = 0;
    repeat (15) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort no done", ndone, 0);
    run_op(8'd9, 8'd3, q, r, z, lat, b1);
    check("post-abort latency", lat, 10);
    check("post-abort quotient", int'(q), 3);

    // random back-to-back ops against the arithmetic model
    for (int i = 0; i < 1000; i++) begin
      logic [N-1:0] a, d, eq, er;
      logic ez;
      int el;
      a = N'($urandom);
      d = ($urandom_range(0, 15) == 0) ? '0 : N'($urandom);
      if (d == '0) begin
        eq = {N{DBZ_Q_BIT}}; er = a; ez = 1'b1; el = 2;
      end else begin
        eq = a / d; er = a % d; ez = 1'b0; el = N + 2;
      end
      run_op(a, d, q, r, z, lat, b1);
      check($sformatf("rnd%0d %0d/%0d latency", i, a, d), lat, el);
      check($sformatf("rnd%0d %0d/%0d quotient", i, a, d), int'(q), int'(eq));
      check($sformatf("rnd%0d %0d/%0d remainder", i, a, d), int'(r), int'(er));
      check($sformatf("rnd%0d %0d/%0d dbz", i, a, d), int'(z), int'(ez));
      if (!ez)
        check($sformatf("rnd%0d %0d/%0d q*d+r", i, a, d),
              bin_mul(int'(q), int'(d)) + int'(r), int'(a));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_bin_div_seq

`default_nettype wire
